if_stage_top: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipelined RV32I core; sits directly upstream of id_stage_top.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/if_skid_buf.sv | 27 ++
 rtl/if_stage_top.sv | 86 ++++++++
 tb/tb_if_stage_top.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and types used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // Fetch issued in the previous cycle whose data is arriving now
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } fetch_slot_t;

    // Instruction fetch is word granular; low address bits are dropped
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register that keeps an instruction alive while the stage is stalled.
module if_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] din,
    output logic            valid,
    output logic [XLEN-1:0] dout
);

    // Reset and clear take priority over a capture in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/if_stage_top.sv
// Instruction-fetch stage: PC register, synchronous imem interface and IF/ID pipeline register.
module if_stage_top
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    logic [31:0] pc_q;
    fetch_slot_t f2_q;
    logic        buf_valid;
    logic [31:0] buf_instr;
    logic [31:0] f2_instr;
    logic        skid_capture;
    logic        skid_clear;
    logic        f2_take;

    // Memory request and the data source for the instruction in flight
    always_comb begin
        imem_addr    = pc_q;
        imem_req     = reset & ~stall & ~redirect_valid;
        f2_instr     = buf_valid ? buf_instr : imem_rdata;
        // Memory data lasts only one cycle, so park it on the first stalled edge
        skid_capture = stall & f2_q.valid & ~buf_valid;
        skid_clear   = redirect_valid | ~stall;
        f2_take      = f2_q.valid & ~flush;
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .capture (skid_capture),
        .clear   (skid_clear),
        .din     (imem_rdata),
        .valid   (buf_valid),
        .dout    (buf_instr)
    );

    // PC, F2 slot and IF/ID register; priority reset > redirect > flush > stall > advance
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q           <= RESET_PC;
            f2_q           <= '0;
            if_id_valid    <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            pc_q        <= align_word(redirect_pc);
            f2_q.valid  <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (stall) begin
            // Flush still squashes IF/ID while PC and F2 hold
            if (flush) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end
        end else begin
            if_id_valid    <= f2_take;
            if_id_instr    <= f2_take ? f2_instr : NOP_INSTR;
            if_id_pc       <= f2_q.pc;
            if_id_pc_plus4 <= f2_q.pc + PC_INC;
            f2_q.valid     <= imem_req;
            f2_q.pc        <= pc_q;
            if (imem_req) begin
                pc_q <= pc_q + PC_INC;
            end
        end
    end

endmodule

// File: tb/tb_if_stage_top.sv
// Testbench for if_stage_top: directed vector table plus randomized run against a queue model.
module tb_if_stage_top;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage_top #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    // Instruction memory contents: a bijection of the address so every word is distinct
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous memory: data only for the address requested last cycle
    always @(posedge clk) begin
        imem_rdata <= imem_req ? memf(imem_addr) : 32'hxxxx_xxxx;
    end

    // Reference model: next fetch address plus an ordered queue of fetches in flight
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_valid;
    logic [31:0] m_pc_out;
    logic        m_rst;

    task automatic model_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] rpc);
        if (!r) begin
            m_pc = RST_PC;
            m_q.delete();
            m_valid = 1'b0;
            m_pc_out = '0;
            m_rst = 1'b1;
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00};
            m_q.delete();
            m_valid = 1'b0;
            m_rst = 1'b0;
        end else begin
            if (f) m_valid = 1'b0;
            if (!s) begin
                m_rst = 1'b0;
                if (m_q.size() > 0) begin
                    m_pc_out = m_q.pop_front();
                    m_valid = !f;
                end else begin
                    m_valid = 1'b0;
                end
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset = r;
        stall = s;
        flush = f;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic clock_edge(input logic r, input logic s, input logic f,
                              input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        model_edge(r, s, f, rv, rpc);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        fl;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        chk_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic fl, input logic rv,
                                input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc, input logic [31:0] p4,
                                input logic chk_pc);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.p4 = p4; v.chk_pc = chk_pc;
        return v;
    endfunction

    vec_t tbl[33];

    initial begin
        // rst st fl rv rpc | req addr | valid pc p4 chk_pc
        tbl[0]  = mk(0,0,0,0,32'h0,          0,32'h0,        0,32'h0,        32'h0,   1);
        tbl[1]  = mk(0,0,0,0,32'h0,          0,32'h0,        0,32'h0,        32'h0,   1);
        tbl[2]  = mk(0,0,0,0,32'h0,          0,32'h0,        0,32'h0,        32'h0,   1);
        tbl[3]  = mk(1,0,0,0,32'h0,          1,32'h0,        0,32'h0,        32'h0,   0);
        tbl[4]  = mk(1,0,0,0,32'h0,          1,32'h4,        1,32'h0,        32'h4,   1);
        tbl[5]  = mk(1,0,0,0,32'h0,          1,32'h8,        1,32'h4,        32'h8,   1);
        tbl[6]  = mk(1,0,0,0,32'h0,          1,32'hC,        1,32'h8,        32'hC,   1);
        tbl[7]  = mk(1,1,0,0,32'h0,          0,32'h10,       1,32'h8,        32'hC,   1);
        tbl[8]  = mk(1,1,0,0,32'h0,          0,32'h10,       1,32'h8,        32'hC,   1);
        tbl[9]  = mk(1,1,0,0,32'h0,          0,32'h10,       1,32'h8,        32'hC,   1);
        tbl[10] = mk(1,0,0,0,32'h0,          1,32'h10,       1,32'hC,        32'h10,  1);
        tbl[11] = mk(1,0,0,0,32'h0,          1,32'h14,       1,32'h10,       32'h14,  1);
        tbl[12] = mk(1,0,1,1,32'h100,        0,32'h18,       0,32'h0,        32'h0,   0);
        tbl[13] = mk(1,0,0,0,32'h0,          1,32'h100,      0,32'h0,        32'h0,   0);
        tbl[14] = mk(1,0,0,0,32'h0,          1,32'h104,      1,32'h100,      32'h104, 1);
        tbl[15] = mk(1,0,0,0,32'h0,          1,32'h108,      1,32'h104,      32'h108, 1);
        tbl[16] = mk(1,1,0,1,32'h200,        0,32'h10C,      0,32'h0,        32'h0,   0);
        tbl[17] = mk(1,0,0,0,32'h0,          1,32'h200,      0,32'h0,        32'h0,   0);
        tbl[18] = mk(1,0,0,1,32'h103,        0,32'h204,      0,32'h0,        32'h0,   0);
        tbl[19] = mk(1,0,0,0,32'h0,          1,32'h100,      0,32'h0,        32'h0,   0);
        tbl[20] = mk(1,0,0,1,32'hFFFF_FFFC,  0,32'h104,      0,32'h0,        32'h0,   0);
        tbl[21] = mk(1,0,0,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,        32'h0,   0);
        tbl[22] = mk(1,0,0,0,32'h0,          1,32'h0,        1,32'hFFFF_FFFC,32'h0,   1);
        tbl[23] = mk(1,0,0,0,32'h0,          1,32'h4,        1,32'h0,        32'h4,   1);
        tbl[24] = mk(1,1,0,0,32'h0,          0,32'h8,        1,32'h0,        32'h4,   1);
        tbl[25] = mk(0,1,0,0,32'h0,          0,32'h8,        0,32'h0,        32'h0,   1);
        tbl[26] = mk(1,0,0,0,32'h0,          1,32'h0,        0,32'h0,        32'h0,   0);
        tbl[27] = mk(1,0,0,0,32'h0,          1,32'h4,        1,32'h0,        32'h4,   1);
        tbl[28] = mk(1,0,0,0,32'h0,          1,32'h8,        1,32'h4,        32'h8,   1);
        tbl[29] = mk(1,1,1,0,32'h0,          0,32'hC,        0,32'h0,        32'h0,   0);
        tbl[30] = mk(1,0,0,0,32'h0,          1,32'hC,        1,32'h8,        32'hC,   1);
        tbl[31] = mk(1,0,1,0,32'h0,          1,32'h10,       0,32'h0,        32'h0,   0);
        tbl[32] = mk(1,0,0,0,32'h0,          1,32'h14,       1,32'h10,       32'h14,  1);

        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        // One unchecked reset edge so the PC is defined before the first row
        clock_edge(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Directed vectors
        for (int i = 0; i < 33; i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].rv, tbl[i].rpc);
            check($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            clock_edge(tbl[i].rst, tbl[i].st, tbl[i].fl, tbl[i].rv, tbl[i].rpc);
            check($sformatf("row%0d if_id_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].valid});
            check($sformatf("row%0d if_id_instr", i), if_id_instr,
                  tbl[i].valid ? memf(tbl[i].pc) : NOP);
            if (tbl[i].chk_pc) begin
                check($sformatf("row%0d if_id_pc", i), if_id_pc, tbl[i].pc);
                check($sformatf("row%0d if_id_pc_plus4", i), if_id_pc_plus4, tbl[i].p4);
            end
        end

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, f, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 39) != 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 9) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
            drive(r, s, f, rv, rpc);
            check("rand imem_req", {31'b0, imem_req}, {31'b0, r & ~s & ~rv});
            check("rand imem_addr", imem_addr, m_pc);
            clock_edge(r, s, f, rv, rpc);
            check("rand if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            check("rand if_id_instr", if_id_instr, m_valid ? memf(m_pc_out) : NOP);
            if (m_valid || m_rst) begin
                check("rand if_id_pc", if_id_pc, m_pc_out);
                check("rand if_id_pc_plus4", if_id_pc_plus4, m_rst ? 32'h0 : m_pc_out + 32'd4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
